// File: rtl/mdl_xxx_shake_sponge_if.sv
// ---------------------------------------------------------------------------
// mdl_xxx_shake_sponge_if
// Bundle of every non-clock signal of the SHAKE sponge controller.
//   slave  : seen by the sponge (mdl_xxx_shake_sponge)
//   master : seen by whoever drives it (requester plus permutation core)
// Groups:
//   command   iSTART, iMODE, iOUT_LANES
//   absorb    iIN_DATA, iIN_VALID, iIN_LAST, iIN_BYTES / oIN_READY
//   squeeze   oOUT_DATA, oOUT_VALID / iOUT_READY
//   status    oBUSY, oDONE
//   core      oKEC_START, oKEC_STATE / iKEC_STATE, iKEC_DONE
// ---------------------------------------------------------------------------
interface mdl_xxx_shake_sponge_if;
    logic          iSTART;
    logic          iMODE;
    logic [15:0]   iOUT_LANES;
    logic [63:0]   iIN_DATA;
    logic          iIN_VALID;
    logic          iIN_LAST;
    logic [3:0]    iIN_BYTES;
    logic          oIN_READY;
    logic [63:0]   oOUT_DATA;
    logic          oOUT_VALID;
    logic          iOUT_READY;
    logic          oBUSY;
    logic          oDONE;
    logic          oKEC_START;
    logic [1599:0] oKEC_STATE;
    logic [1599:0] iKEC_STATE;
    logic          iKEC_DONE;

    modport slave (
        input  iSTART, iMODE, iOUT_LANES,
        input  iIN_DATA, iIN_VALID, iIN_LAST, iIN_BYTES,
        output oIN_READY,
        output oOUT_DATA, oOUT_VALID,
        input  iOUT_READY,
        output oBUSY, oDONE,
        output oKEC_START, oKEC_STATE,
        input  iKEC_STATE, iKEC_DONE
    );

    modport master (
        output iSTART, iMODE, iOUT_LANES,
        output iIN_DATA, iIN_VALID, iIN_LAST, iIN_BYTES,
        input  oIN_READY,
        input  oOUT_DATA, oOUT_VALID,
        output iOUT_READY,
        input  oBUSY, oDONE,
        input  oKEC_START, oKEC_STATE,
        output iKEC_STATE, iKEC_DONE
    );
endinterface

// File: rtl/mdl_xxx_shake_sponge.sv
// ---------------------------------------------------------------------------
// mdl_xxx_shake_sponge
// SHAKE128 / SHAKE256 sponge controller wrapped around an external 24-round
// Keccak-f[1600] core. Holds the 1600-bit state S, XORs in a 64-bit
// little-endian lane stream, applies SHAKE padding (0x1F ... 0x80), kicks the
// core once per block and streams squeezed lanes back out.
// Ports:
//   iSYS_CLK  rising-edge clock
//   iSYS_RST  asynchronous active-low reset
//   bus       mdl_xxx_shake_sponge_if.slave (command, absorb, squeeze,
//             status and core-side signals)
// State layout on oKEC_STATE/iKEC_STATE: lane i at [1599-64i:1536-64i].
// ---------------------------------------------------------------------------
module mdl_xxx_shake_sponge (
    input  logic                  iSYS_CLK,
    input  logic                  iSYS_RST,
    mdl_xxx_shake_sponge_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PAD,
        ST_PERM_START,   // start pulse to the core
        ST_PERM_WAIT,    // waiting for iKEC_DONE, no timeout
        ST_SQUEEZE,
        ST_DONE
    } state_e;

    localparam logic [4:0] RATE_128 = 5'd21;
    localparam logic [4:0] RATE_256 = 5'd17;

    state_e        state_q, state_d;
    logic [1599:0] s_q, s_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [4:0]    rate_q, rate_d;
    logic [4:0]    dom_lane_q, dom_lane_d;
    logic [2:0]    dom_byte_q, dom_byte_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   out_lanes_q, out_lanes_d;
    logic          final_q, final_d;
    logic          pad_pend_q, pad_pend_d;

    logic [63:0]   in_mask;
    logic [63:0]   in_lane;
    logic          last_full;

    // Bit position of the least significant bit of lane `lane` inside S.
    function automatic int lane_lsb(input logic [4:0] lane);
        return 1536 - 64 * int'(lane);
    endfunction

    // Last-lane masking: bytes at or above iIN_BYTES never reach S. Any
    // count of 8 or more is treated as a full lane.
    always_comb begin
        in_mask   = '0;
        last_full = (bus.iIN_BYTES >= 4'd8);
        for (int k = 0; k < 8; k++) begin
            in_mask[8*k +: 8] = (!bus.iIN_LAST || last_full || (k < int'(bus.iIN_BYTES)))
                                ? 8'hFF : 8'h00;
        end
        in_lane = bus.iIN_DATA & in_mask;
    end

    // State and datapath registers.
    // NOTE: S is reset even though it is wide, because oKEC_STATE mirrors it
    // and must read zero out of reset.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            ptr_q       <= '0;
            rate_q      <= '0;
            dom_lane_q  <= '0;
            dom_byte_q  <= '0;
            cnt_q       <= '0;
            out_lanes_q <= '0;
            final_q     <= 1'b0;
            pad_pend_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            s_q         <= s_d;
            ptr_q       <= ptr_d;
            rate_q      <= rate_d;
            dom_lane_q  <= dom_lane_d;
            dom_byte_q  <= dom_byte_d;
            cnt_q       <= cnt_d;
            out_lanes_q <= out_lanes_d;
            final_q     <= final_d;
            pad_pend_q  <= pad_pend_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every target holds its value by default so no path through
        // the case statement can infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        ptr_d       = ptr_q;
        rate_d      = rate_q;
        dom_lane_d  = dom_lane_q;
        dom_byte_d  = dom_byte_q;
        cnt_d       = cnt_q;
        out_lanes_d = out_lanes_q;
        final_d     = final_q;
        pad_pend_d  = pad_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    s_d         = '0;
                    ptr_d       = '0;
                    cnt_d       = '0;
                    rate_d      = bus.iMODE ? RATE_256 : RATE_128;
                    out_lanes_d = bus.iOUT_LANES;
                    final_d     = 1'b0;
                    pad_pend_d  = 1'b0;
                    state_d     = ST_ABSORB;
                end
            end

            ST_ABSORB: begin
                if (bus.iIN_VALID) begin
                    s_d[lane_lsb(ptr_q) +: 64] = s_q[lane_lsb(ptr_q) +: 64] ^ in_lane;
                    if (!bus.iIN_LAST) begin
                        if (ptr_q == rate_q - 5'd1) begin
                            ptr_d   = '0;
                            final_d = 1'b0;
                            state_d = ST_PERM_START;
                        end else begin
                            ptr_d = ptr_q + 5'd1;
                        end
                    end else if (!last_full) begin
                        dom_lane_d = ptr_q;
                        dom_byte_d = bus.iIN_BYTES[2:0];
                        state_d    = ST_PAD;
                    end else if (ptr_q != rate_q - 5'd1) begin
                        dom_lane_d = ptr_q + 5'd1;
                        dom_byte_d = '0;
                        state_d    = ST_PAD;
                    end else begin
                        // Block is full: permute it first, pad an empty block after.
                        dom_lane_d = '0;
                        dom_byte_d = '0;
                        pad_pend_d = 1'b1;
                        ptr_d      = '0;
                        final_d    = 1'b0;
                        state_d    = ST_PERM_START;
                    end
                end
            end

            ST_PAD: begin
                // Written as two read-modify-writes on s_d so that both XORs
                // land when the domain byte sits in the last rate lane.
                s_d[lane_lsb(dom_lane_q) + 8*int'(dom_byte_q) +: 8] =
                    s_d[lane_lsb(dom_lane_q) + 8*int'(dom_byte_q) +: 8] ^ 8'h1F;
                s_d[lane_lsb(rate_q - 5'd1) + 56 +: 8] =
                    s_d[lane_lsb(rate_q - 5'd1) + 56 +: 8] ^ 8'h80;
                final_d = 1'b1;
                state_d = ST_PERM_START;
            end

            ST_PERM_START: state_d = ST_PERM_WAIT;

            ST_PERM_WAIT: begin
                if (bus.iKEC_DONE) begin
                    s_d = bus.iKEC_STATE;
                    if (!final_q) begin
                        if (pad_pend_q) begin
                            pad_pend_d = 1'b0;
                            state_d    = ST_PAD;
                        end else begin
                            state_d = ST_ABSORB;
                        end
                    end else begin
                        // Final and squeeze permutations both resume squeezing at lane 0.
                        ptr_d   = '0;
                        state_d = (out_lanes_q == 16'd0) ? ST_DONE : ST_SQUEEZE;
                    end
                end
            end

            ST_SQUEEZE: begin
                if (bus.iOUT_READY) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == out_lanes_q) begin
                        state_d = ST_DONE;
                    end else if (ptr_q == rate_q - 5'd1) begin
                        ptr_d   = '0;
                        state_d = ST_PERM_START;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        bus.oIN_READY  = (state_q == ST_ABSORB);
        bus.oOUT_VALID = (state_q == ST_SQUEEZE);
        bus.oOUT_DATA  = (state_q == ST_SQUEEZE) ? s_q[lane_lsb(ptr_q) +: 64] : 64'd0;
        bus.oBUSY      = (state_q != ST_IDLE);
        bus.oDONE      = (state_q == ST_DONE);
        bus.oKEC_START = (state_q == ST_PERM_START);
        bus.oKEC_STATE = s_q;
    end

endmodule
